// File: rtl/ex_hilo_mac_pkg.sv
// rtl/ex_hilo_mac_pkg.sv - shared bus types, aluop codes and stall constants for the HI/LO MAC unit
package ex_hilo_mac_pkg;

    typedef logic [31:0] RegBus;
    typedef logic [7:0]  AluOpBus;
    typedef logic [63:0] DoubleRegBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam AluOpBus EXE_NOP_OP   = 8'b0000_0000;
    localparam AluOpBus EXE_MFHI_OP  = 8'b0001_0000;
    localparam AluOpBus EXE_MTHI_OP  = 8'b0001_0001;
    localparam AluOpBus EXE_MFLO_OP  = 8'b0001_0010;
    localparam AluOpBus EXE_MTLO_OP  = 8'b0001_0011;
    localparam AluOpBus EXE_MULT_OP  = 8'b0001_1000;
    localparam AluOpBus EXE_MULTU_OP = 8'b0001_1001;
    localparam AluOpBus EXE_MADD_OP  = 8'b1010_0110;
    localparam AluOpBus EXE_MADDU_OP = 8'b1010_1000;
    localparam AluOpBus EXE_MUL_OP   = 8'b1010_1001;
    localparam AluOpBus EXE_MSUB_OP  = 8'b1010_1010;
    localparam AluOpBus EXE_MSUBU_OP = 8'b1010_1011;

    // Ops whose operands are treated as two's complement by the multiplier
    function automatic logic is_signed_op(input AluOpBus op);
        return (op == EXE_MULT_OP) || (op == EXE_MUL_OP) ||
               (op == EXE_MADD_OP) || (op == EXE_MSUB_OP);
    endfunction

endpackage

// File: rtl/ex_hilo_mac_mul_core.sv
// rtl/ex_hilo_mac_mul_core.sv - combinational 32x32->64 multiplier with signed/unsigned select
module ex_hilo_mac_mul_core
    import ex_hilo_mac_pkg::*;
(
    input  logic        signed_i,
    input  RegBus       a_i,
    input  RegBus       b_i,
    output DoubleRegBus prod_o
);

    DoubleRegBus a_ext;
    DoubleRegBus b_ext;

    // Extending to the full result width makes a plain 64-bit product equal to the
    // low 64 bits of the 33-bit signed/unsigned product.
    assign a_ext  = {{32{signed_i & a_i[31]}}, a_i};
    assign b_ext  = {{32{signed_i & b_i[31]}}, b_i};
    assign prod_o = a_ext * b_ext;

endmodule

// File: rtl/ex_hilo_mac.sv
// rtl/ex_hilo_mac.sv - EX-stage HI/LO multiply/accumulate unit; MAC_MSUB_EN enables MSUB/MSUBU
module ex_hilo_mac
    import ex_hilo_mac_pkg::*;
#(
    parameter int DW         = 32,
    parameter int ACC_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic          stall_i,
    input  logic [7:0]    aluop_i,
    input  logic [DW-1:0] reg1_i,
    input  logic [DW-1:0] reg2_i,
    output logic [DW-1:0] res_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          stallreq_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    // A two-cycle accumulate is what needs the one-cycle hold of the pipeline
    localparam logic ACC_STALL = (ACC_CYCLES == 2);

    state_t      state_q;
    state_t      state_d;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    DoubleRegBus prod_q;
    DoubleRegBus prod;
    DoubleRegBus acc_sum;
    logic        commit;
    logic        load_prod;
    logic        acc_commit;
    logic        is_mult;
    logic        is_mul;
    logic        is_mthi;
    logic        is_mtlo;
    logic        is_mfhi;
    logic        is_mflo;
    logic        is_madd;
    logic        acc_op;

    assign commit  = valid_i && !stall_i;
    assign is_mult = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
    assign is_mul  = (aluop_i == EXE_MUL_OP);
    assign is_mthi = (aluop_i == EXE_MTHI_OP);
    assign is_mtlo = (aluop_i == EXE_MTLO_OP);
    assign is_mfhi = (aluop_i == EXE_MFHI_OP);
    assign is_mflo = (aluop_i == EXE_MFLO_OP);
    assign is_madd = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP);

`ifdef MAC_MSUB_EN
    logic is_msub;
    logic sub_q;
    assign is_msub = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign acc_op  = is_madd || is_msub;
    assign acc_sum = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
`else
    assign acc_op  = is_madd;
    assign acc_sum = {hi_q, lo_q} + prod_q;
`endif

    ex_hilo_mac_mul_core u_mul_core (
        .signed_i (is_signed_op(aluop_i)),
        .a_i      (reg1_i),
        .b_i      (reg2_i),
        .prod_o   (prod)
    );

    // Accumulate FSM: request a stall on entry, capture the product, add it in on the next commit
    always_comb begin
        state_d    = state_q;
        stallreq_o = NoStop;
        load_prod  = 1'b0;
        acc_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rst && valid_i && acc_op) begin
                    stallreq_o = ACC_STALL ? Stop : NoStop;
                    if (!stall_i) begin
                        load_prod = 1'b1;
                        state_d   = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (!valid_i) begin
                    state_d = S_IDLE;
                end else if (!stall_i) begin
                    acc_commit = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // GPR result: MUL low word or HI/LO readout, zero for everything else
    always_comb begin
        res_o = '0;
        if (rst && valid_i) begin
            if (is_mul) begin
                res_o = prod[DW-1:0];
            end else if (is_mfhi) begin
                res_o = hi_q;
            end else if (is_mflo) begin
                res_o = lo_q;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // HI/LO and captured-product registers; single-cycle ops only commit from IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            prod_q <= '0;
`ifdef MAC_MSUB_EN
            sub_q  <= 1'b0;
`endif
        end else begin
            if (load_prod) begin
                prod_q <= prod;
`ifdef MAC_MSUB_EN
                sub_q  <= is_msub;
`endif
            end
            if (acc_commit) begin
                {hi_q, lo_q} <= acc_sum;
            end else if (state_q == S_IDLE && commit) begin
                if (is_mult) begin
                    {hi_q, lo_q} <= prod;
                end
                if (is_mthi) begin
                    hi_q <= reg1_i;
                end
                if (is_mtlo) begin
                    lo_q <= reg1_i;
                end
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_hilo_mac.sv
// tb/tb_ex_hilo_mac.sv - directed self-checking bench for ex_hilo_mac
module tb_ex_hilo_mac;
    import ex_hilo_mac_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        stall_i;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [31:0] res_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    int tests;
    int fails;

    ex_hilo_mac #(.DW(32), .ACC_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .stall_i    (stall_i),
        .aluop_i    (aluop_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .res_o      (res_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; one tick crosses exactly one rising edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        valid_i = v;
        stall_i = s;
        aluop_i = op;
        reg1_i  = a;
        reg2_i  = b;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b0, EXE_MUL_OP, 32'd5, 32'd7);
        #1;
        tests++;
        if (res_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_res got %h want %h", res_o, 32'h0);
        end
        aluop_i = EXE_MADD_OP;
        #1;
        tests++;
        if (stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_stallreq got %b want 0", stallreq_o);
        end
        tick();
        tests++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_hilo got %h_%h want 0_0", hi_o, lo_o);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_mult();
        drive(1'b1, 1'b0, EXE_MULT_OP, 32'hFFFFFFFE, 32'h00000003);
        #1;
        tests++;
        if (stallreq_o !== 1'b0 || res_o !== 32'h0) begin
            fails++;
            $display("FAIL mult_comb stallreq %b res %h want 0 0", stallreq_o, res_o);
        end
        tick();
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        #1;
        tests++;
        if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'hFFFFFFFA || stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL mult_hilo got %h_%h stall %b want ffffffff_fffffffa 0", hi_o, lo_o, stallreq_o);
        end
    endtask

    task automatic test_multu();
        drive(1'b1, 1'b0, EXE_MULTU_OP, 32'hFFFFFFFE, 32'h00000003);
        tick();
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        tests++;
        if (hi_o !== 32'h00000002 || lo_o !== 32'hFFFFFFFA) begin
            fails++;
            $display("FAIL multu_hilo got %h_%h want 00000002_fffffffa", hi_o, lo_o);
        end
    endtask

    task automatic test_maddu();
        int stalls;
        stalls = 0;
        drive(1'b1, 1'b0, EXE_MTHI_OP, 32'h1, 32'h0);
        tick();
        drive(1'b1, 1'b0, EXE_MTLO_OP, 32'h2, 32'h0);
        tick();
        tests++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
            fails++;
            $display("FAIL mthi_mtlo got %h_%h want 00000001_00000002", hi_o, lo_o);
        end
        drive(1'b1, 1'b0, EXE_MADDU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int c = 0; c < 2; c++) begin
            #1;
            if (stallreq_o === 1'b1) stalls++;
            tick();
        end
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        #1;
        if (stallreq_o === 1'b1) stalls++;
        tests++;
        if (stalls !== 1) begin
            fails++;
            $display("FAIL maddu_stall_cycles got %0d want 1", stalls);
        end
        tests++;
        if (hi_o !== 32'hFFFFFFFF || lo_o !== 32'h00000003) begin
            fails++;
            $display("FAIL maddu_hilo got %h_%h want ffffffff_00000003", hi_o, lo_o);
        end
    endtask

    task automatic test_msub();
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_stall;
`ifdef MAC_MSUB_EN
        exp_hi    = 32'hFFFFFFFF;
        exp_lo    = 32'hFFFFFFFA;
        exp_stall = 1'b1;
`else
        exp_hi    = 32'h0;
        exp_lo    = 32'h0;
        exp_stall = 1'b0;
`endif
        do_reset();
        drive(1'b1, 1'b0, EXE_MSUB_OP, 32'd2, 32'd3);
        #1;
        tests++;
        if (stallreq_o !== exp_stall || res_o !== 32'h0) begin
            fails++;
            $display("FAIL msub_first_cycle stall %b res %h want %b 0", stallreq_o, res_o, exp_stall);
        end
        tick();
        tick();
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        tests++;
        if (hi_o !== exp_hi || lo_o !== exp_lo) begin
            fails++;
            $display("FAIL msub_hilo got %h_%h want %h_%h", hi_o, lo_o, exp_hi, exp_lo);
        end
    endtask

    task automatic test_madd_stall();
        do_reset();
        drive(1'b1, 1'b0, EXE_MTLO_OP, 32'd100, 32'h0);
        tick();
        drive(1'b1, 1'b0, EXE_MADD_OP, 32'd4, 32'd5);
        tick();
        // Held in ACC by a downstream stall; operands change to prove prod_q is held
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, EXE_MADD_OP, 32'd9 + c, 32'd11);
            #1;
            tests++;
            if (stallreq_o !== 1'b0 || lo_o !== 32'd100) begin
                fails++;
                $display("FAIL madd_hold_%0d stall %b lo %h want 0 00000064", c, stallreq_o, lo_o);
            end
            tick();
        end
        drive(1'b1, 1'b0, EXE_MADD_OP, 32'd7, 32'd7);
        tick();
        drive(1'b1, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        tests++;
        if (hi_o !== 32'h0 || lo_o !== 32'd120) begin
            fails++;
            $display("FAIL madd_stall_commit got %h_%h want 00000000_00000078", hi_o, lo_o);
        end
    endtask

    task automatic test_reset_acc();
        drive(1'b1, 1'b0, EXE_MTHI_OP, 32'h55, 32'h0);
        tick();
        drive(1'b1, 1'b0, EXE_MADD_OP, 32'd4, 32'd5);
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (stallreq_o !== 1'b0 || res_o !== 32'h0) begin
            fails++;
            $display("FAIL rst_acc_comb stall %b res %h want 0 0", stallreq_o, res_o);
        end
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0 || stallreq_o !== 1'b1) begin
            fails++;
            $display("FAIL rst_acc got %h_%h stall %b want 0_0 1", hi_o, lo_o, stallreq_o);
        end
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, EXE_MADD_OP, 32'd4, 32'd5);
        tick();
        drive(1'b0, 1'b0, EXE_MADD_OP, 32'd4, 32'd5);
        tick();
        drive(1'b1, 1'b1, EXE_MADD_OP, 32'd4, 32'd5);
        #1;
        tests++;
        if (stallreq_o !== 1'b1 || lo_o !== 32'h0) begin
            fails++;
            $display("FAIL flush stall %b lo %h want 1 00000000", stallreq_o, lo_o);
        end
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_mul_mf();
        drive(1'b1, 1'b0, EXE_MTHI_OP, 32'h11, 32'h0);
        tick();
        drive(1'b1, 1'b0, EXE_MTLO_OP, 32'h22, 32'h0);
        tick();
        drive(1'b1, 1'b0, EXE_MUL_OP, 32'hFFFFFFFB, 32'h00000007);
        #1;
        tests++;
        if (res_o !== 32'hFFFFFFDD || stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL mul_res got %h stall %b want ffffffdd 0", res_o, stallreq_o);
        end
        tick();
        tests++;
        if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
            fails++;
            $display("FAIL mul_hilo got %h_%h want 00000011_00000022", hi_o, lo_o);
        end
        drive(1'b1, 1'b0, EXE_MFLO_OP, 32'h0, 32'h0);
        #1;
        tests++;
        if (res_o !== 32'h22) begin
            fails++;
            $display("FAIL mflo_res got %h want 00000022", res_o);
        end
        aluop_i = EXE_MFHI_OP;
        #1;
        tests++;
        if (res_o !== 32'h11) begin
            fails++;
            $display("FAIL mfhi_res got %h want 00000011", res_o);
        end
        valid_i = 1'b0;
        #1;
        tests++;
        if (res_o !== 32'h0) begin
            fails++;
            $display("FAIL bubble_res got %h want 00000000", res_o);
        end
        drive(1'b1, 1'b0, EXE_NOP_OP, 32'h5, 32'h6);
        #1;
        tests++;
        if (res_o !== 32'h0 || stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL nop_res got %h stall %b want 0 0", res_o, stallreq_o);
        end
        drive(1'b0, 1'b0, EXE_MTHI_OP, 32'hABCD, 32'h0);
        tick();
        tests++;
        if (hi_o !== 32'h11) begin
            fails++;
            $display("FAIL bubble_mthi got %h want 00000011", hi_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, EXE_NOP_OP, 32'h0, 32'h0);
        @(negedge clk);
        test_reset();
        test_mult();
        test_multu();
        test_maddu();
        test_msub();
        test_madd_stall();
        test_reset_acc();
        test_flush();
        test_mul_mf();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
